alu_serial_responder: RTL and testbench

- Sequential, request/response-driven counterpart to the combinational alu that the team's fixtures drive directly.
- Accepts one operand pair plus opcode per transaction and computes it SLICE bits per cycle, LSB slice first.
- Returns the SIZE+1-bit result and O/Z/N flags through a valid/ready response port.
- Sits between a sequencer/bus initiator and the datapath, where a full-width single-cycle adder is not wanted.

---
 rtl/alu_serial_responder.sv | 194 +++++++++++++++++++
 tb/tb_alu_serial_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_responder.sv
// alu_serial_responder
// Request/response ALU that evaluates add, sub, AND and OR one SLICE-bit
// chunk per cycle, LSB slice first. It returns a SIZE+1-bit result and the
// O/Z/N flags through a valid/ready response port.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both high. Valid, once raised, stays high with
// stable payload until that transfer. req_ready is combinational from
// rsp_ready in DONE, so a response can retire and the next request can be
// accepted on the same edge.
module alu_serial_responder #(
    parameter int SIZE  = 32,
    parameter int SLICE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    input  logic [1:0]      CTRL,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [SIZE:0]   R,
    output logic            O,
    output logic            Z,
    output logic            N
);

    localparam int NS = SIZE / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // State and datapath registers. The _d signals are next-state values.
    state_t          state_q, state_d;
    logic [SIZE-1:0] a_q, a_d;
    logic [SIZE-1:0] b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            nz_q, nz_d;
    logic [SIZE:0]   r_q, r_d;
    logic            o_q, o_d;
    logic            z_q, z_d;
    logic            n_q, n_d;

    // Slice datapath signals.
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] b_eff;
    logic [SLICE:0]   sum_sl;
    logic [SLICE-1:0] res_sl;
    logic             ovf_sl;
    logic             is_arith;
    logic             last_slice;
    logic             capture;

    // Select the current operand slice and evaluate it. Subtraction is
    // a + ~b + carry, with the carry preloaded to 1 at capture time.
    always_comb begin
        a_sl       = a_q[int'(cnt_q)*SLICE +: SLICE];
        b_sl       = b_q[int'(cnt_q)*SLICE +: SLICE];
        b_eff      = (op_q == OP_SUB) ? ~b_sl : b_sl;
        sum_sl     = {1'b0, a_sl} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
        is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
        last_slice = (cnt_q == CW'(NS - 1));
        // Signed overflow equals carry-in XOR carry-out at the MSB. That is
        // the same as: operand signs agree and the result sign differs.
        ovf_sl     = (a_sl[SLICE-1] == b_eff[SLICE-1]) &&
                     (sum_sl[SLICE-1] != a_sl[SLICE-1]);
        case (op_q)
            OP_AND:  res_sl = a_sl & b_sl;
            OP_OR:   res_sl = a_sl | b_sl;
            default: res_sl = sum_sl[SLICE-1:0];
        endcase
    end

    // Next-state logic: FSM transitions, slice writes and request capture.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        nz_d    = nz_q;
        r_d     = r_q;
        o_d     = o_q;
        z_d     = z_q;
        n_d     = n_q;
        capture = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                r_d[int'(cnt_q)*SLICE +: SLICE] = res_sl;
                carry_d = sum_sl[SLICE];
                nz_d    = nz_q | (|res_sl);
                cnt_d   = cnt_q + 1'b1;
                if (last_slice) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    z_d     = ~(nz_q | (|res_sl));
                    if (is_arith) begin
                        r_d[SIZE] = sum_sl[SLICE];
                        o_d       = ovf_sl;
                        n_d       = res_sl[SLICE-1];
                    end else begin
                        r_d[SIZE] = 1'b0;
                        o_d       = 1'b0;
                        n_d       = 1'b0;
                    end
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    if (req_valid) begin
                        capture = 1'b1;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The operands are sampled only here. Later changes on A, B or CTRL
        // cannot reach the result.
        if (capture) begin
            a_d     = A;
            b_d     = B;
            op_d    = CTRL;
            carry_d = (CTRL == OP_SUB);
            cnt_d   = '0;
            nz_d    = 1'b0;
        end
    end

    // Register update. Reset discards any transaction that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            nz_q    <= 1'b0;
            r_q     <= '0;
            o_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            nz_q    <= nz_d;
            r_q     <= r_d;
            o_q     <= o_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    // Handshake outputs and the registered result/flags.
    always_comb begin
        req_ready = (state_q == IDLE) || ((state_q == DONE) && rsp_ready);
        rsp_valid = (state_q == DONE);
        R         = r_q;
        O         = o_q;
        Z         = z_q;
        N         = n_q;
    end

endmodule

// File: tb/tb_alu_serial_responder.sv
// Bench for alu_serial_responder. It uses directed vectors with hand-computed
// results. Expected {R,O,Z,N} values and response cycles are queued when a
// request is accepted. A monitor process pops and compares each response.
module tb_alu_serial_responder;

    localparam int SIZE  = 32;
    localparam int SLICE = 8;
    localparam int NS    = SIZE / SLICE;
    localparam int EW    = SIZE + 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [SIZE-1:0] A;
    logic [SIZE-1:0] B;
    logic [1:0]      CTRL;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [SIZE:0]   R;
    logic            O;
    logic            Z;
    logic            N;

    alu_serial_responder #(.SIZE(SIZE), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .A         (A),
        .B         (B),
        .CTRL      (CTRL),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .R         (R),
        .O         (O),
        .Z         (Z),
        .N         (N)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [EW-1:0] exp_q[$];
    int            lat_q[$];
    int            n_cmp   = 0;
    int            n_err   = 0;
    bit            pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: checks the first-valid cycle and the payload at retirement.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pending = 1'b0;
            end else begin
                if (rsp_valid && !pending) begin
                    pending = 1'b1;
                    if (lat_q.size() == 0) flag_fail("unexpected_response");
                    else check("latency", 64'(cyc), 64'(lat_q.pop_front()));
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) flag_fail("unexpected_retire");
                    else check("response", 64'({R, O, Z, N}), 64'(exp_q.pop_front()));
                    pending = 1'b0;
                end
            end
        end
    end

    // Driver: present a request, wait (bounded) for acceptance, queue expectation.
    task automatic send(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic [1:0] op, input logic [EW-1:0] e,
                        input bit push, input bit rr);
        int t;
        @(negedge clk);
        A         = a;
        B         = b;
        CTRL      = op;
        req_valid = 1'b1;
        rsp_ready = rr;
        #1;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!req_ready) begin
            flag_fail("req_accept_timeout");
        end else if (push) begin
            exp_q.push_back(e);
            lat_q.push_back(cyc + 1 + NS);
        end
        @(posedge clk);
    endtask

    task automatic release_req();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        rsp_ready = 1'b1;
        do begin
            @(negedge clk);
            #3;
            t++;
        end while ((exp_q.size() != 0 || rsp_valid) && t < 200);
        if (exp_q.size() != 0) flag_fail("drain_timeout");
    endtask

    // Directed vectors
    logic [SIZE-1:0] va[8]   = '{32'hFFFFF000, 32'h67676767, 32'hFFFFFFFF, 32'h7FFFFFFF,
                                 32'h80000000, 32'hF0F0F0F0, 32'h00000000, 32'h00000000};
    logic [SIZE-1:0] vb[8]   = '{32'hFFFFFFFF, 32'h12431243, 32'hFFFFFFFF, 32'h00000001,
                                 32'h00000001, 32'hCFCFCFCF, 32'h11000001, 32'h11000001};
    logic [1:0]      vop[8]  = '{OP_ADD, OP_SUB, OP_SUB, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_AND};
    logic [EW-1:0]   vexp[8] = '{{33'h1_FFFFEFFF, 3'b001}, {33'h1_55245524, 3'b000},
                                 {33'h1_00000000, 3'b010}, {33'h0_80000000, 3'b101},
                                 {33'h1_7FFFFFFF, 3'b100}, {33'h0_C0C0C0C0, 3'b000},
                                 {33'h0_11000001, 3'b000}, {33'h0_00000000, 3'b010}};

    localparam logic [EW-1:0] EXP_BP  = {33'h0_23456789, 3'b000};
    localparam logic [EW-1:0] EXP_B2B = {33'h0_FFFFFFFE, 3'b001};
    localparam logic [EW-1:0] EXP_RST = {33'h1_00000000, 3'b010};

    initial begin
        int t;
        rst       = 1'b1;
        req_valid = 1'b0;
        A         = '0;
        B         = '0;
        CTRL      = OP_ADD;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({R, O, Z, N}), 64'd0);
        check("reset_handshake", 64'({req_ready, rsp_valid}), 64'b10);
        rst = 1'b0;

        // Isolated transactions
        for (int i = 0; i < 8; i++) begin
            send(va[i], vb[i], vop[i], vexp[i], 1'b1, 1'b1);
            release_req();
            drain();
        end

        // Same vectors back-to-back
        for (int i = 0; i < 8; i++) begin
            send(va[i], vb[i], vop[i], vexp[i], 1'b1, 1'b1);
        end
        release_req();
        drain();

        // Backpressure, with operand inputs toggled while BUSY
        send(32'h12345678, 32'h11111111, OP_ADD, EXP_BP, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            A         = $urandom;
            B         = $urandom;
            CTRL      = 2'($urandom_range(0, 3));
        end
        t = 0;
        while (!rsp_valid && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!rsp_valid) flag_fail("bp_wait_timeout");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check("hold_outputs", 64'({R, O, Z, N}), 64'(EXP_BP));
            check("hold_handshake", 64'({req_ready, rsp_valid}), 64'b01);
        end
        // Retire and accept the next request on the same edge
        send(32'h00000005, 32'h00000007, OP_SUB, EXP_B2B, 1'b1, 1'b1);
        release_req();
        drain();

        // Reset during slice 2 of an add
        send(32'h0F0F0F0F, 32'h01010101, OP_ADD, '0, 1'b0, 1'b1);
        release_req();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset_outputs", 64'({R, O, Z, N}), 64'd0);
        check("midreset_handshake", 64'({req_ready, rsp_valid}), 64'b10);
        @(negedge clk);
        rst = 1'b0;
        send(32'hFFFFFFFF, 32'h00000001, OP_ADD, EXP_RST, 1'b1, 1'b1);
        release_req();
        drain();

        repeat (3) @(negedge clk);
        if (lat_q.size() != 0) flag_fail("leftover_latency_entries");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
